// File: rtl/rip_wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : rip_wb_scoreboard
//  Purpose  : Write-side front end of the integer register file. Merges the
//             in-order MA-stage result and a long-latency result stream into
//             the single register-file write port. Tracks registers with an
//             outstanding long-latency result in a busy scoreboard, and raises
//             a decode stall on RAW/WAW hazards.
//  Ports    : clk, rst_n (async, active-low)
//             ma_wen/ma_rd/ma_wdata        MA-stage write, never backpressured
//             lu_valid/lu_ready/lu_rd/lu_wdata  long-latency result handshake
//             iss_valid/iss_rd             long-latency issue, marks busy
//             if_rs1_num/if_rs2_num/if_rd_num  decode operands, feed stall
//             stall                        combinational hazard indication
//             wb_wen/wb_rd_num/wb_wdata    register-file write port
//             busy_vec                     scoreboard state (debug)
//             sb_err                       sticky protocol-error flag
//  Config   : RIP_WB_FAST_EN - combinational write port and same-cycle
//             stall masking of the committing long-latency register.
//  Revision : 1.0 - initial release
// ============================================================================
module rip_wb_scoreboard #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ma_wen,
   input  logic [4:0]      ma_rd,
   input  logic [XLEN-1:0] ma_wdata,
   input  logic            lu_valid,
   output logic            lu_ready,
   input  logic [4:0]      lu_rd,
   input  logic [XLEN-1:0] lu_wdata,
   input  logic            iss_valid,
   input  logic [4:0]      iss_rd,
   input  logic [4:0]      if_rs1_num,
   input  logic [4:0]      if_rs2_num,
   input  logic [4:0]      if_rd_num,
   output logic            stall,
   output logic            wb_wen,
   output logic [4:0]      wb_rd_num,
   output logic [XLEN-1:0] wb_wdata,
   output logic [NREG-1:0] busy_vec,
   output logic            sb_err
);

   // One-entry hold buffer for a long-latency beat displaced by an MA write
   logic            hold_valid;
   logic [4:0]      hold_rd;
   logic [XLEN-1:0] hold_wdata;

   logic [NREG-1:0] busy;
   logic            err_q;

   // Selected commit for this cycle
   logic            cm_valid;
   logic            cm_long;
   logic [4:0]      cm_rd;
   logic [XLEN-1:0] cm_wdata;
   logic            cm_wen;

   logic            lu_acc;
   logic [NREG-1:0] clr_mask;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] busy_eff;
   logic            err_now;

   // Ready depends only on registered state, never on lu_valid
   assign lu_ready = !hold_valid;
   assign lu_acc   = lu_valid && !hold_valid;

   // Priority: MA write, then hold buffer, then a directly accepted lu beat
   always_comb begin
      cm_valid = 1'b0;
      cm_long  = 1'b0;
      cm_rd    = '0;
      cm_wdata = '0;
      if (ma_wen) begin
         cm_valid = 1'b1;
         cm_rd    = ma_rd;
         cm_wdata = ma_wdata;
      end else if (hold_valid) begin
         cm_valid = 1'b1;
         cm_long  = 1'b1;
         cm_rd    = hold_rd;
         cm_wdata = hold_wdata;
      end else if (lu_acc) begin
         cm_valid = 1'b1;
         cm_long  = 1'b1;
         cm_rd    = lu_rd;
         cm_wdata = lu_wdata;
      end
   end

   // x0 commits complete their handshake but never reach the register file
   assign cm_wen   = cm_valid && (cm_rd != 5'd0);

   // x0 is never busy, so neither mask ever touches bit 0
   assign clr_mask = (cm_long && cm_rd != 5'd0)       ? (NREG'(1) << cm_rd)  : '0;
   assign set_mask = (iss_valid && iss_rd != 5'd0)    ? (NREG'(1) << iss_rd) : '0;

   // Errors: long-latency commit to an idle register, or issue to a register
   // still busy after this cycle's clear is applied
   assign err_now  = (|(clr_mask & ~busy)) || (|(set_mask & busy & ~clr_mask));

`ifdef RIP_WB_FAST_EN
   // The committing register is forwarded by the register file this cycle
   assign busy_eff = busy & ~clr_mask;
`else
   assign busy_eff = busy;
`endif

   assign stall = (busy_eff[if_rs1_num] && (if_rs1_num != 5'd0)) ||
                  (busy_eff[if_rs2_num] && (if_rs2_num != 5'd0)) ||
                  (busy_eff[if_rd_num]  && (if_rd_num  != 5'd0));

   assign busy_vec = busy;
   assign sb_err   = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid <= 1'b0;
         hold_rd    <= '0;
         hold_wdata <= '0;
         busy       <= '0;
         err_q      <= 1'b0;
      end else begin
         if (ma_wen && lu_acc) begin
            hold_valid <= 1'b1;
            hold_rd    <= lu_rd;
            hold_wdata <= lu_wdata;
         end else if (!ma_wen && hold_valid) begin
            hold_valid <= 1'b0;
         end
         // Clear first, then set, so a same-register set wins
         busy <= (busy & ~clr_mask) | set_mask;
         if (err_now) begin
            err_q <= 1'b1;
         end
      end
   end

`ifdef RIP_WB_FAST_EN
   assign wb_wen    = cm_wen;
   assign wb_rd_num = cm_rd;
   assign wb_wdata  = cm_wdata;
`else
   logic            wb_wen_q;
   logic [4:0]      wb_rd_q;
   logic [XLEN-1:0] wb_wdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_wen_q   <= 1'b0;
         wb_rd_q    <= '0;
         wb_wdata_q <= '0;
      end else begin
         wb_wen_q <= cm_wen;
         if (cm_wen) begin
            wb_rd_q    <= cm_rd;
            wb_wdata_q <= cm_wdata;
         end
      end
   end

   assign wb_wen    = wb_wen_q;
   assign wb_rd_num = wb_rd_q;
   assign wb_wdata  = wb_wdata_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rip_wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rip_wb_scoreboard
//  Purpose  : Self-checking bench for rip_wb_scoreboard (default build).
//             Directed scenarios followed by randomized traffic, all compared
//             against a queue-based reference model of the write-back rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rip_wb_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ma_wen;
   logic [4:0]  ma_rd;
   logic [31:0] ma_wdata;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_rd;
   logic [31:0] lu_wdata;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic [4:0]  if_rs1_num, if_rs2_num, if_rd_num;
   logic        stall;
   logic        wb_wen;
   logic [4:0]  wb_rd_num;
   logic [31:0] wb_wdata;
   logic [31:0] busy_vec;
   logic        sb_err;

   rip_wb_scoreboard #(.XLEN(32), .NREG(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .ma_wen(ma_wen), .ma_rd(ma_rd), .ma_wdata(ma_wdata),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_wdata(lu_wdata),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .if_rs1_num(if_rs1_num), .if_rs2_num(if_rs2_num), .if_rd_num(if_rd_num),
      .stall(stall), .wb_wen(wb_wen), .wb_rd_num(wb_rd_num), .wb_wdata(wb_wdata),
      .busy_vec(busy_vec), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   // Reference model state
   wr_t         hq[$];
   logic [31:0] m_busy;
   logic        m_err;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clr_in();
      ma_wen = 0; ma_rd = 0; ma_wdata = 0;
      lu_valid = 0; lu_rd = 0; lu_wdata = 0;
      iss_valid = 0; iss_rd = 0;
      if_rs1_num = 0; if_rs2_num = 0; if_rd_num = 0;
   endtask

   // One clock cycle with the currently driven inputs; checks ready/stall
   // before the edge and the write port / scoreboard after it.
   task automatic cycle();
      bit  exp_rdy, exp_st, acc, cv, cl, e_wen;
      wr_t c;
      c = '{5'd0, 32'd0};
      exp_rdy = (hq.size() == 0);
      exp_st  = (m_busy[if_rs1_num] && if_rs1_num != 0) ||
                (m_busy[if_rs2_num] && if_rs2_num != 0) ||
                (m_busy[if_rd_num]  && if_rd_num  != 0);
      @(negedge clk);
      check("lu_ready", lu_ready, exp_rdy);
      check("stall", stall, exp_st);
      acc = lu_valid && exp_rdy;
      cv = 0; cl = 0;
      if (ma_wen) begin
         cv = 1; c = '{ma_rd, ma_wdata};
         if (acc) hq.push_back('{lu_rd, lu_wdata});
      end else if (hq.size() > 0) begin
         cv = 1; cl = 1; c = hq.pop_front();
      end else if (acc) begin
         cv = 1; cl = 1; c = '{lu_rd, lu_wdata};
      end
      if (cl && c.rd != 0) begin
         if (!m_busy[c.rd]) m_err = 1;
         m_busy[c.rd] = 1'b0;
      end
      if (iss_valid && iss_rd != 0) begin
         if (m_busy[iss_rd]) m_err = 1;
         m_busy[iss_rd] = 1'b1;
      end
      e_wen = cv && (c.rd != 0);
      @(posedge clk);
      #1;
      check("wb_wen", wb_wen, e_wen);
      if (e_wen) begin
         check("wb_rd_num", wb_rd_num, c.rd);
         check("wb_wdata", wb_wdata, c.data);
      end
      check("busy_vec", busy_vec, m_busy);
      check("sb_err", sb_err, m_err);
   endtask

   task automatic do_reset();
      clr_in();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      hq.delete();
      m_busy = '0;
      m_err  = 0;
      check("rst_wb_wen", wb_wen, 0);
      check("rst_wb_rd", wb_rd_num, 0);
      check("rst_wb_wdata", wb_wdata, 0);
      check("rst_busy", busy_vec, 0);
      check("rst_sb_err", sb_err, 0);
      check("rst_lu_ready", lu_ready, 1);
   endtask

   initial begin
      clr_in();
      rst_n  = 0;
      m_busy = '0;
      m_err  = 0;
      #2;
      do_reset();

      // Basic MA write, one-cycle latency
      ma_wen = 1; ma_rd = 5; ma_wdata = 32'h1234;
      cycle();
      check("basic_wen", wb_wen, 1);
      check("basic_rd", wb_rd_num, 5);
      check("basic_data", wb_wdata, 32'h1234);
      check("basic_stall", stall, 0);

      // Issue then return
      clr_in(); iss_valid = 1; iss_rd = 7;
      cycle();
      check("iss_busy7", busy_vec[7], 1);
      clr_in(); if_rs1_num = 7;
      cycle();
      check("iss_stall", stall, 1);
      lu_valid = 1; lu_rd = 7; lu_wdata = 32'hBEEF;
      cycle();
      check("ret_rd", wb_rd_num, 7);
      check("ret_data", wb_wdata, 32'hBEEF);
      check("ret_busy7", busy_vec[7], 0);
      check("ret_stall", stall, 0);

      // Collision: MA rd=3 and lu rd=9 together, then MA held 3 cycles
      clr_in(); iss_valid = 1; iss_rd = 9;
      cycle();
      clr_in();
      ma_wen = 1; ma_rd = 3; ma_wdata = 32'h33;
      lu_valid = 1; lu_rd = 9; lu_wdata = 32'h99;
      cycle();
      check("col_first_rd", wb_rd_num, 3);
      lu_valid = 0;
      for (int i = 0; i < 3; i++) begin
         ma_rd = 5'(10 + i); ma_wdata = 32'(100 + i);
         cycle();
         check("col_hold_wait", lu_ready, 0);
      end
      clr_in();
      cycle();
      check("col_drain_rd", wb_rd_num, 9);
      check("col_drain_data", wb_wdata, 32'h99);
      check("col_ready_back", lu_ready, 1);

      // x0 long-latency return
      clr_in(); lu_valid = 1; lu_rd = 0; lu_wdata = 32'hDEAD;
      cycle();
      check("x0_wen", wb_wen, 0);

      // Set wins over a same-cycle clear
      clr_in(); iss_valid = 1; iss_rd = 4;
      cycle();
      clr_in(); iss_valid = 1; iss_rd = 4; lu_valid = 1; lu_rd = 4; lu_wdata = 32'h44;
      cycle();
      check("setwin_busy4", busy_vec[4], 1);
      clr_in(); lu_valid = 1; lu_rd = 4; lu_wdata = 32'h45;
      cycle();

      // Error flag: commit to a non-busy register
      clr_in(); lu_valid = 1; lu_rd = 12; lu_wdata = 32'hC0C0;
      cycle();
      check("err_wen", wb_wen, 1);
      check("err_rd", wb_rd_num, 12);
      check("err_flag", sb_err, 1);
      clr_in();
      repeat (3) cycle();
      check("err_sticky", sb_err, 1);

      // Randomized traffic
      do_reset();
      for (int n = 0; n < 400; n++) begin
         ma_wen     = ($urandom % 2) == 0;
         ma_rd      = 5'($urandom % 8);
         ma_wdata   = $urandom;
         lu_valid   = ($urandom % 5) < 2;
         lu_rd      = 5'($urandom % 8);
         lu_wdata   = $urandom;
         iss_valid  = ($urandom % 4) == 0;
         iss_rd     = 5'($urandom % 8);
         if_rs1_num = 5'($urandom % 8);
         if_rs2_num = 5'($urandom % 8);
         if_rd_num  = 5'($urandom % 8);
         cycle();
      end

      // Asynchronous reset with hold buffer full and busy_vec = 0x80
      do_reset();
      lu_valid = 1; lu_rd = 12; lu_wdata = 32'h12;
      cycle();
      clr_in(); iss_valid = 1; iss_rd = 7;
      cycle();
      clr_in();
      ma_wen = 1; ma_rd = 1; ma_wdata = 32'h11;
      lu_valid = 1; lu_rd = 7; lu_wdata = 32'h77;
      cycle();
      check("pre_async_busy", busy_vec, 32'h80);
      check("pre_async_ready", lu_ready, 0);
      #2;
      rst_n = 0;
      #1;
      check("async_wb_wen", wb_wen, 0);
      check("async_busy", busy_vec, 0);
      check("async_ready", lu_ready, 1);
      check("async_sb_err", sb_err, 0);
      clr_in();
      @(posedge clk);
      #1;
      rst_n = 1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
